// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RV32I writeback stage: MEM/WB register, load extraction, regfile write port
// Optional retire counter built only when WB_INSTRET_EN is defined.
module wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              mem_valid_i,
    input  logic              mem_rd_wren_i,
    input  logic [ADDR_W-1:0] mem_rd_addr_i,
    input  logic [1:0]        mem_wb_sel_i,
    input  logic [DATA_W-1:0] mem_alu_data_i,
    input  logic [DATA_W-1:0] mem_pc_i,
    input  logic [DATA_W-1:0] mem_ld_data_i,
    input  logic [2:0]        mem_ld_funct3_i,
    input  logic [1:0]        mem_ld_off_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              regs_wr_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              wb_valid_o,
    output logic [31:0]       instret_o
);

    logic              valid_q;
    logic              wren_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [1:0]        wb_sel_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] ld_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            wren_q    <= 1'b0;
            rd_addr_q <= '0;
            wb_sel_q  <= '0;
            alu_q     <= '0;
            pc_q      <= '0;
            ld_q      <= '0;
            funct3_q  <= '0;
            off_q     <= '0;
        end else if (flush_i) begin
            // Only valid is cleared; the remaining fields are dead once valid is 0.
            valid_q <= 1'b0;
        end else if (!stall_i) begin
            valid_q   <= mem_valid_i;
            wren_q    <= mem_rd_wren_i;
            rd_addr_q <= mem_rd_addr_i;
            wb_sel_q  <= mem_wb_sel_i;
            alu_q     <= mem_alu_data_i;
            pc_q      <= mem_pc_i;
            ld_q      <= mem_ld_data_i;
            funct3_q  <= mem_ld_funct3_i;
            off_q     <= mem_ld_off_i;
        end
    end

    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_ext;

    always_comb begin
        ld_byte = ld_q[{off_q, 3'b000} +: 8];
        // Halfword ignores off[0]; misalignment is handled upstream.
        ld_half = ld_q[{off_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  ld_ext = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {{(DATA_W-8){1'b0}}, ld_byte};
            3'b001:  ld_ext = {{(DATA_W-16){ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {{(DATA_W-16){1'b0}}, ld_half};
            default: ld_ext = ld_q;
        endcase
    end

    always_comb begin
        case (wb_sel_q)
            2'b01:   rd_data_o = ld_ext;
            2'b10:   rd_data_o = pc_q + DATA_W'(4);
            default: rd_data_o = alu_q;
        endcase
    end

    assign regs_wr_en_o = valid_q & wren_q & (rd_addr_q != '0);
    assign rd_addr_o    = rd_addr_q;
    assign wb_valid_o   = valid_q;

`ifdef WB_INSTRET_EN
    logic [31:0] instret_q;

    // Retirement is the instruction leaving WB, so a same-edge flush does not cancel it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instret_q <= '0;
        end else if (valid_q && !stall_i) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret_o = instret_q;
`else
    assign instret_o = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_valid, m_wren;
    logic [4:0]  m_rd;
    logic [1:0]  m_sel;
    logic [31:0] m_alu, m_pc, m_ld;
    logic [2:0]  m_f3;
    logic [1:0]  m_off;
    logic        stall, flush;
    logic        wr_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        wb_valid;
    logic [31:0] instret;

    int n_checks = 0;
    int n_errors = 0;
    // Reference retire bookkeeping: whether WB holds a valid instruction and how many retired.
    logic        ref_valid = 1'b0;
    int unsigned ref_ret = 0;

    always #5 clk = ~clk;

    wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .mem_valid_i     (m_valid),
        .mem_rd_wren_i   (m_wren),
        .mem_rd_addr_i   (m_rd),
        .mem_wb_sel_i    (m_sel),
        .mem_alu_data_i  (m_alu),
        .mem_pc_i        (m_pc),
        .mem_ld_data_i   (m_ld),
        .mem_ld_funct3_i (m_f3),
        .mem_ld_off_i    (m_off),
        .stall_i         (stall),
        .flush_i         (flush),
        .regs_wr_en_o    (wr_en),
        .rd_addr_o       (rd_addr),
        .rd_data_o       (rd_data),
        .wb_valid_o      (wb_valid),
        .instret_o       (instret)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] ld,
                         input logic [2:0] f3, input logic [1:0] off);
        m_valid = v; m_wren = w; m_rd = rd; m_sel = sel;
        m_alu = alu; m_pc = pc; m_ld = ld; m_f3 = f3; m_off = off;
    endtask

    task automatic cyc();
        if (ref_valid && !stall) ref_ret++;
        ref_valid = flush ? 1'b0 : (stall ? ref_valid : m_valid);
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] exp_ret(input int unsigned n);
`ifdef WB_INSTRET_EN
        return n;
`else
        return 32'd0;
`endif
    endfunction

    task automatic check_wb(input string tag, input logic e_wr, input logic [4:0] e_rd, input logic [31:0] e_data);
        check({tag, ".wr_en"}, {31'd0, wr_en}, {31'd0, e_wr});
        check({tag, ".rd_addr"}, {27'd0, rd_addr}, {27'd0, e_rd});
        check({tag, ".rd_data"}, rd_data, e_data);
    endtask

    initial begin
        stall = 1'b0; flush = 1'b0;
        drive(0, 0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        cyc(); cyc();
        check_wb("reset", 1'b0, 5'd0, 32'h0);
        check("reset.wb_valid", {31'd0, wb_valid}, 32'd0);
        check("reset.instret", instret, 32'd0);
        rst_n = 1'b1;

        drive(1, 1, 5'd2, 2'b00, 32'hABCD_ABCD, 32'h0, 32'h0, 3'b000, 2'd0);
        cyc();
        check_wb("alu", 1'b1, 5'd2, 32'hABCD_ABCD);
        check("alu.wb_valid", {31'd0, wb_valid}, 32'd1);

        drive(1, 1, 5'd3, 2'b01, 32'h0, 32'h0, 32'h8070_F0AA, 3'b000, 2'd0); cyc();
        check("lb_off0", rd_data, 32'hFFFF_FFAA);
        drive(1, 1, 5'd3, 2'b01, 32'h0, 32'h0, 32'h8070_F0AA, 3'b100, 2'd1); cyc();
        check("lbu_off1", rd_data, 32'h0000_00F0);
        drive(1, 1, 5'd3, 2'b01, 32'h0, 32'h0, 32'h8070_F0AA, 3'b001, 2'd2); cyc();
        check("lh_off2", rd_data, 32'hFFFF_8070);
        drive(1, 1, 5'd3, 2'b01, 32'h0, 32'h0, 32'h8070_F0AA, 3'b101, 2'd3); cyc();
        check("lhu_off3", rd_data, 32'h0000_8070);
        drive(1, 1, 5'd3, 2'b01, 32'h0, 32'h0, 32'h8070_F0AA, 3'b001, 2'd1); cyc();
        check("lh_off1", rd_data, 32'hFFFF_F0AA);
        drive(1, 1, 5'd3, 2'b01, 32'h0, 32'h0, 32'h8070_F0AA, 3'b010, 2'd1); cyc();
        check("lw_off1", rd_data, 32'h8070_F0AA);
        drive(1, 1, 5'd3, 2'b01, 32'h0, 32'h0, 32'h8070_F0AA, 3'b111, 2'd2); cyc();
        check("ld_other", rd_data, 32'h8070_F0AA);

        drive(1, 1, 5'd0, 2'b00, 32'h0000_1234, 32'h0, 32'h0, 3'b000, 2'd0); cyc();
        check_wb("x0", 1'b0, 5'd0, 32'h0000_1234);

        drive(1, 1, 5'd4, 2'b10, 32'h0, 32'h0000_0100, 32'h0, 3'b000, 2'd0); cyc();
        check("pc4", rd_data, 32'h0000_0104);
        drive(1, 1, 5'd4, 2'b10, 32'h0, 32'hFFFF_FFFC, 32'h0, 3'b000, 2'd0); cyc();
        check("pc4_wrap", rd_data, 32'h0000_0000);
        drive(1, 1, 5'd4, 2'b11, 32'h0000_7777, 32'h0000_0100, 32'h0, 3'b000, 2'd0); cyc();
        check("sel11_alu", rd_data, 32'h0000_7777);
        drive(1, 0, 5'd6, 2'b00, 32'h0000_0066, 32'h0, 32'h0, 3'b000, 2'd0); cyc();
        check_wb("nowren", 1'b0, 5'd6, 32'h0000_0066);
        check("instret_run", instret, exp_ret(ref_ret));

        drive(1, 1, 5'd5, 2'b00, 32'h0000_0055, 32'h0, 32'h0, 3'b000, 2'd0); cyc();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 5'(7 + i), 2'b10, 32'h1111_0000 + i, 32'h200, 32'h0, 3'b000, 2'd0);
            cyc();
            check_wb("stall", 1'b1, 5'd5, 32'h0000_0055);
            check("stall.instret", instret, exp_ret(ref_ret));
        end
        flush = 1'b1; cyc();
        check("flush_stall.wb_valid", {31'd0, wb_valid}, 32'd0);
        check("flush_stall.wr_en", {31'd0, wr_en}, 32'd0);
        check("flush_stall.instret", instret, exp_ret(ref_ret));
        flush = 1'b0; stall = 1'b0;

        // Asynchronous reset while a stalled instruction is held.
        drive(1, 1, 5'd9, 2'b00, 32'h0000_0099, 32'h0, 32'h0, 3'b000, 2'd0); cyc();
        stall = 1'b1; cyc();
        rst_n = 1'b0;
        #1;
        check_wb("rst_stall", 1'b0, 5'd0, 32'h0);
        check("rst_stall.wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_stall.instret", instret, 32'd0);
        stall = 1'b0;
        drive(0, 0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        ref_valid = 1'b0; ref_ret = 0;

        drive(1, 1, 5'd1, 2'b00, 32'h1, 32'h0, 32'h0, 3'b000, 2'd0); cyc();
        drive(1, 1, 5'd2, 2'b00, 32'h2, 32'h0, 32'h0, 3'b000, 2'd0); cyc();
        drive(0, 0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0); cyc();
        drive(1, 1, 5'd3, 2'b00, 32'h3, 32'h0, 32'h0, 3'b000, 2'd0); cyc();
        drive(1, 0, 5'd4, 2'b00, 32'h4, 32'h0, 32'h0, 3'b000, 2'd0); cyc();
        drive(0, 0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0); cyc();
        drive(1, 1, 5'd5, 2'b00, 32'h5, 32'h0, 32'h0, 3'b000, 2'd0); cyc();
        drive(0, 0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0); cyc();
        check("retire5", instret, exp_ret(5));
        check("retire5.wb_valid", {31'd0, wb_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
